// File: rtl/rx_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : rx_gearbox
// Brief    : PCS lane receive gearbox; repacks DATA_W-bit deserializer words
//            into 66-bit blocks (2-bit sync header + 64-bit payload) and
//            applies single-bit slips requested by block sync.
// Revision : 1.0 - initial release
// ============================================================================
module rx_gearbox #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bitslip,
    output logic [1:0]        sync_bits,
    output logic [63:0]       payload,
    output logic              block_valid
);

    localparam int BLOCK_W = 66;
    localparam int BUF_W   = 65;
    localparam int COMB_W  = BUF_W + 64;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("rx_gearbox: DATA_W must be 32 or 64");
        end
    endgenerate

    logic [BUF_W-1:0]  bit_buf;
    logic [6:0]        fill;
    logic              slip_pend;

    logic [COMB_W-1:0] comb_raw;
    logic [COMB_W-1:0] comb;
    logic [7:0]        total_raw;
    logic [7:0]        total;
    logic              take;
    logic [6:0]        fill_nxt;
    logic [BUF_W-1:0]  keep_mask;
    logic [BUF_W-1:0]  buf_nxt;

    always_comb begin
        comb_raw  = COMB_W'(bit_buf) | (COMB_W'(data_in) << fill);
        total_raw = {1'b0, fill} + 8'(DATA_W);

        // A pending slip discards the oldest bit before any block is cut.
        if (slip_pend) begin
            comb  = comb_raw >> 1;
            total = total_raw - 8'd1;
        end else begin
            comb  = comb_raw;
            total = total_raw;
        end

        take = (total >= 8'd66);
        if (take) begin
            fill_nxt = 7'(total - 8'd66);
            buf_nxt  = {2'b00, comb[COMB_W-1:BLOCK_W]};
        end else begin
            fill_nxt = total[6:0];
            buf_nxt  = comb[BUF_W-1:0];
        end

        keep_mask = ~({BUF_W{1'b1}} << fill_nxt);
        buf_nxt   = buf_nxt & keep_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_buf     <= '0;
            fill        <= '0;
            slip_pend   <= 1'b0;
            sync_bits   <= 2'b00;
            payload     <= '0;
            block_valid <= 1'b0;
        end else begin
            bit_buf     <= buf_nxt;
            fill        <= fill_nxt;
            block_valid <= take;
            // Only a freshly presented header may trigger a slip.
            slip_pend   <= block_valid & bitslip;
            if (take) begin
                sync_bits <= comb[1:0];
                payload   <= comb[BLOCK_W-1:2];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_gearbox
// Brief    : Directed bench for rx_gearbox at DATA_W=32 and DATA_W=64 against
//            a bit-position stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_gearbox;

    localparam int STREAM_LEN = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data32;
    logic        bitslip32;
    logic [1:0]  sync32;
    logic [63:0] pay32;
    logic        valid32;
    logic [63:0] data64;
    logic        bitslip64;
    logic [1:0]  sync64;
    logic [63:0] pay64;
    logic        valid64;

    always #5 clk = ~clk;

    rx_gearbox #(.DATA_W(32)) dut32 (
        .clk(clk), .reset(reset), .data_in(data32), .bitslip(bitslip32),
        .sync_bits(sync32), .payload(pay32), .block_valid(valid32)
    );

    rx_gearbox #(.DATA_W(64)) dut64 (
        .clk(clk), .reset(reset), .data_in(data64), .bitslip(bitslip64),
        .sync_bits(sync64), .payload(pay64), .block_valid(valid64)
    );

    int checks = 0;
    int errors = 0;
    bit stream [0:STREAM_LEN-1];
    bit hist   [0:127];
    int slips_model;
    int win_pulses;
    int late_bad;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [63:0] get_word(input int c, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = stream[c*w + i];
        return r;
    endfunction

    function automatic logic [65:0] get_block(input int p);
        logic [65:0] r;
        for (int i = 0; i < 66; i++) r[i] = stream[p + i];
        return r;
    endfunction

    function automatic int sum_hist(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) n += int'(hist[i]);
        return n;
    endfunction

    task automatic fill_const(input bit val);
        for (int i = 0; i < STREAM_LEN; i++) stream[i] = val;
    endtask

    task automatic fill_random();
        for (int i = 0; i < STREAM_LEN; i++) stream[i] = 1'($urandom_range(0, 1));
    endtask

    // Blocks start at 'offset'; with tail_fix every misaligned 2-bit window is 00/11.
    task automatic build_blocks(input int offset, input bit tail_fix);
        logic [1:0] hdrs [0:63];
        int base;
        for (int j = 0; j < 64; j++) hdrs[j] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        fill_const(1'b0);
        for (int i = 0; i < offset; i++) stream[i] = hdrs[0][0];
        for (int j = 0; j < 62; j++) begin
            base = offset + 66*j;
            if (base + 66 > STREAM_LEN) break;
            stream[base]   = hdrs[j][0];
            stream[base+1] = hdrs[j][1];
            for (int i = 2; i < 66; i++)
                stream[base+i] = (tail_fix && i >= 61) ? hdrs[j+1][0] : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        data32    = '0;
        data64    = '0;
        bitslip32 = 1'b0;
        bitslip64 = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid32", 66'(valid32), 66'(0));
        check("rst_sync32",  66'(sync32),  66'(0));
        check("rst_pay32",   66'(pay32),   66'(0));
        check("rst_valid64", 66'(valid64), 66'(0));
        check("rst_sync64",  66'(sync64),  66'(0));
        check("rst_pay64",   66'(pay64),   66'(0));
        reset = 1'b0;
    endtask

    // mode 0: no slips; 1: block-sync model; 2: slips at cycles sa/sb; 3: bitslip held cycles sa..sa+9
    task automatic run(input int w, input int ncyc, input int mode, input int sa, input int sb);
        int          pos;
        bit          pend;
        bit          prev_v;
        bit          prev_dut_v;
        bit          req;
        bit          exp_v;
        logic        v;
        logic [1:0]  s;
        logic [63:0] p;
        logic [63:0] wd;
        logic [65:0] eb;
        pos = 0; pend = 0; prev_v = 0; prev_dut_v = 0; req = 0;
        slips_model = 0; win_pulses = 0; late_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (mode == 2) req = (c == sa) || (c == sb);
            else if (mode == 3) req = (c >= sa) && (c < sa + 10);
            else if (mode == 0) req = 1'b0;
            if (mode == 3 && req && prev_dut_v) win_pulses++;
            wd = get_word(c, w);
            if (w == 32) begin
                data32    = wd[31:0];
                bitslip32 = req;
            end else begin
                data64    = wd;
                bitslip64 = req;
            end
            @(posedge clk);
            #1;
            v = (w == 32) ? valid32 : valid64;
            s = (w == 32) ? sync32  : sync64;
            p = (w == 32) ? pay32   : pay64;

            if (pend) pos++;
            exp_v = ((c + 1) * w - pos >= 66);
            pend  = req && prev_v;
            if (pend) slips_model++;

            check("valid", 66'(v), 66'(exp_v));
            if (exp_v) begin
                eb = get_block(pos);
                check("sync", 66'(s), 66'(eb[1:0]));
                check("payload", 66'(p), 66'(eb[65:2]));
                pos += 66;
            end
            prev_v     = exp_v;
            prev_dut_v = v;
            hist[c]    = v;
            if (v && (s == 2'b00 || s == 2'b11) && c >= 40) late_bad++;
            if (mode == 1) req = v && (s == 2'b00 || s == 2'b11);
        end
        bitslip32 = 1'b0;
        bitslip64 = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        data32    = '0;
        data64    = '0;
        bitslip32 = 1'b0;
        bitslip64 = 1'b0;
        #1;
        check("init_valid32", 66'(valid32), 66'(0));

        // Mid-stream reset, then an all-ones stream
        do_reset();
        fill_random();
        run(32, 20, 0, -1, -1);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid32", 66'(valid32), 66'(0));
        check("async_sync32",  66'(sync32),  66'(0));
        check("async_pay32",   66'(pay32),   66'(0));
        @(posedge clk);
        #1;
        check("held_valid32", 66'(valid32), 66'(0));
        reset = 1'b0;
        fill_const(1'b1);
        run(32, 3, 0, -1, -1);
        check("ones_edge1", 66'(hist[0]), 66'(0));
        check("ones_edge2", 66'(hist[1]), 66'(0));
        check("ones_edge3_valid", 66'(valid32), 66'(1));
        check("ones_edge3_sync",  66'(sync32),  66'(2'b11));

        // Aligned block stream, cadence at both widths
        build_blocks(0, 1'b0);
        do_reset();
        run(32, 70, 0, -1, -1);
        check("cadence32", 66'(sum_hist(33, 65)), 66'(16));
        do_reset();
        run(64, 40, 0, -1, -1);
        check("cadence64", 66'(sum_hist(0, 32)), 66'(32));

        // Slip convergence from a 5-bit offset
        build_blocks(5, 1'b1);
        do_reset();
        run(32, 100, 1, -1, -1);
        check("conv_slips", 66'(slips_model), 66'(5));
        check("conv_late_bad", 66'(late_bad), 66'(0));

        // Bitslip held high for 10 cycles
        fill_random();
        do_reset();
        run(32, 50, 3, 20, -1);
        check("stale_slips", 66'(win_pulses), 66'(slips_model));

        // fill=34 plus slip at DATA_W=32: total 65, no block
        fill_random();
        do_reset();
        run(32, 40, 2, 31, -1);
        check("fill34_noblk", 66'(hist[32]), 66'(0));
        check("fill34_next",  66'(hist[33]), 66'(1));

        // fill=65 plus slip at DATA_W=64: total 128, one block, fill 62
        fill_random();
        do_reset();
        run(64, 40, 2, 2, 32);
        check("fill65_gap",   66'(hist[32]), 66'(0));
        check("fill65_blk",   66'(hist[33]), 66'(1));
        check("fill62_blk",   66'(hist[34]), 66'(1));

        // Single 1 at stream bit 70 lands at payload[2] of the second block
        fill_const(1'b0);
        stream[70] = 1'b1;
        do_reset();
        run(32, 5, 0, -1, -1);
        check("bitord_valid", 66'(valid32), 66'(1));
        check("bitord_pay",   66'(pay32),   66'(64'h4));
        check("bitord_sync",  66'(sync32),  66'(2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
